// File: rtl/clz_norm_64b.sv
// Normalization front-end: leading-zero / redundant-sign count for a 64-bit
// operand, pipelined to feed a left shifter with an aligned shift amount.
module clz_norm_64b #(
  parameter bit OUT_REG = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        mode_i,
  input  logic [63:0] in_data_i,
  input  logic        in_valid_i,
  output logic [63:0] out_data_o,
  output logic [5:0]  out_shift_o,
  output logic        out_zero_o,
  output logic        out_valid_o
);

  function automatic logic [3:0] lz8(input logic [7:0] b);
    lz8 = 4'd8;
    for (int i = 0; i < 8; i++)
      if (b[i]) lz8 = 4'(7 - i);
  endfunction

  logic [63:0] t;
  logic [3:0]  b_cnt [8];
  logic [7:0]  b_zero;

  always_comb begin
    t = mode_i ? (in_data_i ^ {64{in_data_i[63]}}) : in_data_i;
    for (int i = 0; i < 8; i++) begin
      b_cnt[i]  = lz8(t[8*i +: 8]);
      b_zero[i] = ~|t[8*i +: 8];
    end
  end

  logic        s1_valid;
  logic        s1_mode;
  logic [63:0] s1_data;
  logic [3:0]  s1_cnt [8];
  logic [7:0]  s1_zero;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_data  <= '0;
      s1_zero  <= '0;
      for (int i = 0; i < 8; i++)
        s1_cnt[i] <= '0;
    end else begin
      s1_valid <= in_valid_i;
      if (in_valid_i) begin
        s1_mode <= mode_i;
        s1_data <= in_data_i;
        s1_zero <= b_zero;
        for (int i = 0; i < 8; i++)
          s1_cnt[i] <= b_cnt[i];
      end
    end
  end

  logic [6:0] cnt;
  logic       done;
  logic       s2_zero;
  logic [5:0] s2_shift;

  // Accumulate whole zero bytes until the first byte holding a set bit.
  always_comb begin
    cnt  = '0;
    done = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (!done) begin
        cnt = cnt + {3'b000, s1_cnt[i]};
        if (!s1_zero[i]) done = 1'b1;
      end
    end
    s2_zero = &s1_zero;
    if (s1_mode)
      s2_shift = s2_zero ? 6'd63 : 6'(cnt - 7'd1);
    else
      s2_shift = cnt[6] ? 6'd63 : cnt[5:0];
  end

  if (OUT_REG) begin : g_out_reg
    always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
        out_valid_o <= 1'b0;
        out_data_o  <= '0;
        out_shift_o <= '0;
        out_zero_o  <= 1'b0;
      end else begin
        out_valid_o <= s1_valid;
        if (s1_valid) begin
          out_data_o  <= s1_data;
          out_shift_o <= s2_shift;
          out_zero_o  <= s2_zero;
        end
      end
    end
  end else begin : g_out_comb
    assign out_valid_o = s1_valid;
    assign out_data_o  = s1_data;
    assign out_shift_o = s2_shift;
    assign out_zero_o  = s2_zero;
  end

endmodule

// File: tb/tb_clz_norm_64b.sv
// Bench for clz_norm_64b: both OUT_REG builds driven in parallel and
// compared each cycle against a bit-counting reference model.
module tb_clz_norm_64b;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode = 1'b0;
  logic        vin = 1'b0;
  logic [63:0] din = '0;

  logic [63:0] o1_data, o0_data;
  logic [5:0]  o1_shift, o0_shift;
  logic        o1_zero, o0_zero;
  logic        o1_valid, o0_valid;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  clz_norm_64b #(.OUT_REG(1'b1)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .mode_i(mode),
    .in_data_i(din), .in_valid_i(vin),
    .out_data_o(o1_data), .out_shift_o(o1_shift),
    .out_zero_o(o1_zero), .out_valid_o(o1_valid)
  );

  clz_norm_64b #(.OUT_REG(1'b0)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .mode_i(mode),
    .in_data_i(din), .in_valid_i(vin),
    .out_data_o(o0_data), .out_shift_o(o0_shift),
    .out_zero_o(o0_zero), .out_valid_o(o0_valid)
  );

  task automatic check(input string tag, input logic [71:0] obs,
                       input logic [71:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: count bits from the top that carry no information.
  function automatic logic [70:0] ref_out(input logic m, input logic [63:0] d);
    int n;
    logic z;
    logic [5:0] s;
    n = 0;
    if (m) begin
      while (n < 63 && d[62 - n] == d[63]) n++;
      z = (n == 63);
    end else begin
      while (n < 64 && d[63 - n] == 1'b0) n++;
      z = (n == 64);
    end
    s = z ? 6'd63 : 6'(n);
    return {z, s, d};
  endfunction

  typedef struct packed {
    logic        rst_n;
    logic        v;
    logic        m;
    logic [63:0] d;
  } smp_t;

  smp_t       hist [2] = '{default: '0};
  logic [70:0] held1 = '0;
  logic [70:0] held0 = '0;

  task automatic predict(input int lat, inout logic [70:0] held,
                         output logic [71:0] exp, output logic m);
    smp_t s;
    bit   rst_seen;
    s = hist[lat - 1];
    rst_seen = !hist[0].rst_n || (lat == 2 && !hist[1].rst_n);
    m = s.m;
    if (rst_seen) begin
      held = '0;
      exp  = '0;
    end else if (s.v) begin
      held = ref_out(s.m, s.d);
      exp  = {1'b1, held};
    end else begin
      exp  = {1'b0, held};
    end
  endtask

  initial begin
    logic [71:0] e1, e0;
    logic        m1, m0;
    logic [63:0] sh;
    forever begin
      @(posedge clk);
      hist[1] = hist[0];
      hist[0] = '{rst_n, vin, mode, din};
      #1;
      predict(2, held1, e1, m1);
      check("pipe_r1", {o1_valid, o1_zero, o1_shift, o1_data}, e1);
      predict(1, held0, e0, m0);
      check("pipe_r0", {o0_valid, o0_zero, o0_shift, o0_data}, e0);
      if (o1_valid && !o1_zero) begin
        sh = o1_data << o1_shift;
        check("norm_r1", {71'd0, m1 ? sh[63] ^ sh[62] : sh[63]}, 72'd1);
      end
      if (o0_valid && !o0_zero) begin
        sh = o0_data << o0_shift;
        check("norm_r0", {71'd0, m0 ? sh[63] ^ sh[62] : sh[63]}, 72'd1);
      end
    end
  end

  task automatic dir(input logic m, input logic [63:0] d,
                     input logic [5:0] xs, input logic xz);
    @(negedge clk);
    vin = 1'b1; mode = m; din = d;
    @(negedge clk);
    vin = 1'b0; mode = ~m; din = {$urandom(), $urandom()};
    check("dir_r0", {o0_valid, o0_zero, o0_shift, o0_data}, {1'b1, xz, xs, d});
    @(negedge clk);
    check("dir_r1", {o1_valid, o1_zero, o1_shift, o1_data}, {1'b1, xz, xs, d});
  endtask

  initial begin
    logic [5:0]  bub;
    logic [63:0] d;
    int          sa;
    repeat (3) @(negedge clk);
    check("rst_r1", {o1_valid, o1_zero, o1_shift, o1_data}, 72'd0);
    check("rst_r0", {o0_valid, o0_zero, o0_shift, o0_data}, 72'd0);
    rst_n = 1'b1;

    dir(1'b0, 64'h0123_4567_89ab_cdef, 6'd7, 1'b0);
    dir(1'b0, 64'h8000_0000_0000_0000, 6'd0, 1'b0);
    dir(1'b0, 64'h0000_0000_0000_0001, 6'd63, 1'b0);
    dir(1'b0, 64'h0, 6'd63, 1'b1);
    dir(1'b1, 64'hFF00_0000_0000_0000, 6'd7, 1'b0);
    dir(1'b1, 64'hC000_0000_0000_0000, 6'd1, 1'b0);
    dir(1'b1, 64'h4000_0000_0000_0000, 6'd0, 1'b0);
    dir(1'b1, 64'h0000_0000_0000_0001, 6'd62, 1'b0);
    dir(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 1'b1);
    dir(1'b1, 64'h0, 6'd63, 1'b1);

    for (int k = 63; k >= 0; k--) begin
      @(negedge clk);
      vin = 1'b1; mode = k[0]; din = 64'd1 << k;
    end

    bub = 6'b100110;
    for (int i = 5; i >= 0; i--) begin
      @(negedge clk);
      vin = bub[i]; mode = 1'($urandom_range(0, 1));
      din = {$urandom(), $urandom()};
    end

    @(negedge clk);
    vin = 1'b1; mode = 1'b0; din = 64'h0000_00F0_0000_0000;
    @(negedge clk);
    din = 64'h0000_0000_0F00_0000;
    @(negedge clk);
    rst_n = 1'b0; din = 64'h1;
    @(negedge clk);
    check("midrst_r1", {o1_valid, o1_zero, o1_shift, o1_data}, 72'd0);
    check("midrst_r0", {o0_valid, o0_zero, o0_shift, o0_data}, 72'd0);
    rst_n = 1'b1; vin = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      d  = {$urandom(), $urandom()};
      sa = $urandom_range(0, 64);
      d  = (sa == 64) ? 64'd0 : d >> sa;
      if ($urandom_range(0, 1) == 1) d = ~d;
      vin  = ($urandom_range(0, 3) != 0);
      mode = 1'($urandom_range(0, 1));
      din  = d;
    end

    @(negedge clk);
    vin = 1'b0;
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clz_norm_64b.md
Name: clz_norm_64b

Overview:
- Normalization front-end that sits directly upstream of shl_64b.
- Takes a 64-bit operand and computes the left-shift amount that normalizes it: leading-zero count (unsigned) or redundant-sign-bit count (signed).
- Emits the unmodified operand, a 6-bit shift amount and a zero flag, aligned and valid-tagged, ready to drive shl_64b in_data_i/shift_i/in_valid_i.
- Fully pipelined: one result per cycle.

Parameters:
OUT_REG, 1, 1 = stage-2 outputs registered (latency 2); 0 = stage-2 combinational from stage-1 registers (latency 1)

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_n_i  input  1  reset, synchronous, active-low
mode_i  input  1  0 = CLZ (unsigned), 1 = CLS (signed, redundant sign bits)
in_data_i  input  64  operand
in_valid_i  input  1  operand valid this cycle
out_data_o  output  64  operand, delayed to align with shift_o
out_shift_o  output  6  normalizing left-shift amount, 0..63
out_zero_o  output  1  operand has no normalizing bit (all-zero in CLZ, all-sign in CLS)
out_valid_o  output  1  outputs valid this cycle

Behaviour:
- Clock and reset: single clock clk_i; reset rst_n_i is synchronous, active-low.
- Reset values: out_valid_o=0, out_data_o=0, out_shift_o=0, out_zero_o=0. All internal pipeline registers are cleared.
- Reset mid-stream: in-flight operands are discarded at the reset edge. Inputs sampled while rst_n_i=0 are ignored. The first valid output after reset release comes from the first in_valid_i sampled with rst_n_i=1.
- Transform (stage 1, combinational before the stage-1 register):
  - CLZ: t = in_data_i.
  - CLS: t = in_data_i XOR {64{in_data_i[63]}}, so t[63] = 0.
- Stage 1 register:
  - Splits t into 8 bytes, byte 7 = bits 63:56.
  - Registers a 4-bit per-byte leading-zero count (0..8) and a per-byte all-zero flag.
  - Also registers in_data_i, mode_i and in_valid_i.
- Stage 2:
  - Priority-combines the byte counts from byte 7 downward: count = 8*(number of leading all-zero bytes) + leading zeros of the first non-zero byte. count is 7 bits, 0..64.
  - zero = (t == 0).
  - CLZ: shift = (count == 64) ? 63 : count.
  - CLS: shift = zero ? 63 : count - 1. count >= 1 is guaranteed because t[63] = 0.
  - Registered when OUT_REG=1; driven directly from the stage-1 registers when OUT_REG=0.
- Latency:
  - in_valid_i to out_valid_o is 1 + OUT_REG cycles.
  - out_data_o, out_shift_o and out_zero_o are always aligned with out_valid_o.
- Valid pipeline:
  - The valid bit shifts unconditionally every cycle.
  - Data, shift and zero registers load only when their stage valid is 1; otherwise they hold their previous value.
  - No backpressure: back-to-back operands yield back-to-back results in the same order.
- Mode is per-operand and travels with its data. Switching mode_i between consecutive cycles must not corrupt either result.
- Saturation: out_shift_o never exceeds 63. The all-zero (CLZ) and all-sign (CLS) cases report 63 with out_zero_o=1.
- Consistency property: for out_zero_o=0, feeding out_data_o/out_shift_o into shl_64b with carry_i=0 must give:
  - CLZ: result bit 63 = 1.
  - CLS: result bits 63 and 62 differ.

Test Plan:
- CLZ, OUT_REG=1: 0x0123_4567_89ab_cdef -> 2 cycles later out_shift_o=7, out_zero_o=0, out_data_o unchanged. 0x8000_0000_0000_0000 -> shift 0. 0x0000_0000_0000_0001 -> shift 63, zero 0. 0 -> shift 63, zero 1.
- CLS: 0xFF00_0000_0000_0000 -> shift 7. 0xC000_0000_0000_0000 -> 1. 0x4000_0000_0000_0000 -> 0. 0x0000_0000_0000_0001 -> 62. 0xFFFF_FFFF_FFFF_FFFF and 0 -> shift 63, zero 1.
- Streaming: walking-one 1<<k for k=63..0, one per cycle, in_valid_i held high, mode alternating per cycle -> CLZ 63-k and CLS max(62-k,0) are both required checks; 64 consecutive valid outputs in order, each with the correct mode's result.
- Bubbles: in_valid_i toggling 1,0,0,1,1,0 -> out_valid_o reproduces the same pattern delayed by 1+OUT_REG; outputs hold during invalid cycles.
- Reset mid-stream: drop rst_n_i for 1 cycle with 2 operands in flight -> out_valid_o=0 and all outputs 0 on the next edge; the in-flight results never appear.
- Chained with shl_64b, carry_i=0, random 10k operands, both modes, both OUT_REG values -> normalization property holds for every non-zero-flag result.
